// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decoder feeding a DEPTH-entry FIFO toward execute, with flush.
// Optional macro DECODE_MULDIV_EN adds the muldiv output and accepts M-extension R-type encodings.
module decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [XLEN-1:0] f_pc,
  input  logic [31:0]     inst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] d_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      shamt,
  output logic            illegal
`ifdef DECODE_MULDIV_EN
  ,
  output logic            muldiv
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [4:0]      shamt;
    logic            illegal;
    logic            muldiv;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  entry_t           dec;
  entry_t           head;
  logic             legal;
  logic             push, pop;

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  assign op = inst[6:0];
  assign f3 = inst[14:12];
  assign f7 = inst[31:25];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Decode the offered word; illegal encodings keep only pc and opcode.
  always_comb begin
    dec        = '0;
    legal      = 1'b1;
    dec.pc     = f_pc;
    dec.opcode = op;
    case (op)
      OP_R: begin
        dec.rd     = inst[11:7];
        dec.rs1    = inst[19:15];
        dec.rs2    = inst[24:20];
        dec.funct3 = f3;
        dec.funct7 = f7;
        case (f7)
          7'b0000000: legal = 1'b1;
          7'b0100000: legal = (f3 == 3'b000) || (f3 == 3'b101);
`ifdef DECODE_MULDIV_EN
          7'b0000001: dec.muldiv = 1'b1;
`endif
          default:    legal = 1'b0;
        endcase
      end
      OP_IMM: begin
        dec.rd     = inst[11:7];
        dec.rs1    = inst[19:15];
        dec.funct3 = f3;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec.shamt  = inst[24:20];
          dec.funct7 = f7;
          legal = (f7 == 7'b0000000) || ((f3 == 3'b101) && (f7 == 7'b0100000));
        end else begin
          dec.imm = XLEN'($signed(inst[31:20]));
        end
      end
      OP_LOAD, OP_JALR, OP_SYSTEM: begin
        dec.rd     = inst[11:7];
        dec.rs1    = inst[19:15];
        dec.funct3 = f3;
        dec.imm    = XLEN'($signed(inst[31:20]));
        if (op == OP_JALR) legal = (f3 == 3'b000);
      end
      OP_STORE: begin
        dec.rs1    = inst[19:15];
        dec.rs2    = inst[24:20];
        dec.funct3 = f3;
        dec.imm    = XLEN'($signed({inst[31:25], inst[11:7]}));
      end
      OP_BRANCH: begin
        dec.rs1    = inst[19:15];
        dec.rs2    = inst[24:20];
        dec.funct3 = f3;
        dec.imm    = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      end
      OP_LUI, OP_AUIPC: begin
        dec.rd  = inst[11:7];
        dec.imm = XLEN'($signed({inst[31:12], 12'b0}));
      end
      OP_JAL: begin
        dec.rd  = inst[11:7];
        dec.imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec         = '0;
      dec.pc      = f_pc;
      dec.opcode  = op;
      dec.illegal = 1'b1;
    end
  end

  // in_ready and out_valid come straight from the occupancy register.
  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = dec;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head entry is presented only while valid; otherwise every field reads zero.
  always_comb begin
    head = '0;
    if (out_valid) head = mem_q[rd_ptr_q];
  end

  assign d_pc    = head.pc;
  assign opcode  = head.opcode;
  assign rd      = head.rd;
  assign rs1     = head.rs1;
  assign rs2     = head.rs2;
  assign funct3  = head.funct3;
  assign funct7  = head.funct7;
  assign imm     = head.imm;
  assign shamt   = head.shamt;
  assign illegal = head.illegal;
`ifdef DECODE_MULDIV_EN
  assign muldiv  = head.muldiv;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode vector table plus backpressure, flush and reset sequences.
module tb_decode_stage;

  localparam int unsigned XLEN = 32;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [XLEN-1:0] f_pc = '0;
  logic [31:0]     inst = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            flush = 1'b0;
  logic            out_ready = 1'b0;
  logic            out_valid;
  logic [XLEN-1:0] d_pc;
  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm;
  logic [4:0]      shamt;
  logic            illegal;
`ifdef DECODE_MULDIV_EN
  logic            muldiv;
`endif

  decode_stage #(.XLEN(XLEN), .DEPTH(2)) dut (
    .clock(clock), .reset_n(reset_n), .f_pc(f_pc), .inst(inst),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_ready(out_ready), .out_valid(out_valid), .d_pc(d_pc),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .shamt(shamt), .illegal(illegal)
`ifdef DECODE_MULDIV_EN
    , .muldiv(muldiv)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] inst;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic        ill;
    logic        md;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_head(input string tag, input vec_t v, input logic [31:0] pc);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " d_pc"},      d_pc, pc);
    chk({tag, " opcode"},    32'(opcode), 32'(v.op));
    chk({tag, " rd"},        32'(rd), 32'(v.rd));
    chk({tag, " rs1"},       32'(rs1), 32'(v.rs1));
    chk({tag, " rs2"},       32'(rs2), 32'(v.rs2));
    chk({tag, " funct3"},    32'(funct3), 32'(v.f3));
    chk({tag, " funct7"},    32'(funct7), 32'(v.f7));
    chk({tag, " imm"},       imm, v.imm);
    chk({tag, " shamt"},     32'(shamt), 32'(v.shamt));
    chk({tag, " illegal"},   32'(illegal), 32'(v.ill));
`ifdef DECODE_MULDIV_EN
    chk({tag, " muldiv"},    32'(muldiv), 32'(v.md));
`endif
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] w);
    f_pc = pc;
    inst = w;
    in_valid = 1'b1;
  endtask

  initial begin
    //            inst          op     rd     rs1    rs2    f3    f7     imm           sh     ill md
    vecs.push_back('{32'hFFF00093, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 5'd0, 1'b0, 1'b0}); // addi x1,x0,-1
    vecs.push_back('{32'hFFDFF0EF, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 5'd0, 1'b0, 1'b0}); // jal x1,-4
    vecs.push_back('{32'h40335293, 7'h13, 5'd5, 5'd6, 5'd0, 3'd5, 7'h20, 32'h00000000, 5'd3, 1'b0, 1'b0}); // srai x5,x6,3
    vecs.push_back('{32'h00209093, 7'h13, 5'd1, 5'd1, 5'd0, 3'd1, 7'h00, 32'h00000000, 5'd2, 1'b0, 1'b0}); // slli x1,x1,2
    vecs.push_back('{32'h40209093, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 5'd0, 1'b1, 1'b0}); // slli with funct7=0x20
    vecs.push_back('{32'h002081B3, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00000000, 5'd0, 1'b0, 1'b0}); // add x3,x1,x2
    vecs.push_back('{32'h402081B3, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h00000000, 5'd0, 1'b0, 1'b0}); // sub x3,x1,x2
    vecs.push_back('{32'h402091B3, 7'h33, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 5'd0, 1'b1, 1'b0}); // sll with funct7=0x20
    vecs.push_back('{32'h0020A423, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'h00000008, 5'd0, 1'b0, 1'b0}); // sw x2,8(x1)
    vecs.push_back('{32'hFE20AE23, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'hFFFFFFFC, 5'd0, 1'b0, 1'b0}); // sw x2,-4(x1)
    vecs.push_back('{32'hFE208CE3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFF8, 5'd0, 1'b0, 1'b0}); // beq x1,x2,-8
    vecs.push_back('{32'h800002B7, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h80000000, 5'd0, 1'b0, 1'b0}); // lui x5,0x80000
    vecs.push_back('{32'h12345397, 7'h17, 5'd7, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 5'd0, 1'b0, 1'b0}); // auipc x7,0x12345
    vecs.push_back('{32'h80012203, 7'h03, 5'd4, 5'd2, 5'd0, 3'd2, 7'h00, 32'hFFFFF800, 5'd0, 1'b0, 1'b0}); // lw x4,-2048(x2)
    vecs.push_back('{32'h000280E7, 7'h67, 5'd1, 5'd5, 5'd0, 3'd0, 7'h00, 32'h00000000, 5'd0, 1'b0, 1'b0}); // jalr x1,0(x5)
    vecs.push_back('{32'h000290E7, 7'h67, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 5'd0, 1'b1, 1'b0}); // jalr funct3=1
    vecs.push_back('{32'h00000073, 7'h73, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 5'd0, 1'b0, 1'b0}); // ecall
    vecs.push_back('{32'h00000000, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 5'd0, 1'b1, 1'b0}); // all-zero word
`ifdef DECODE_MULDIV_EN
    vecs.push_back('{32'h022081B3, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h01, 32'h00000000, 5'd0, 1'b0, 1'b1}); // mul x3,x1,x2
`else
    vecs.push_back('{32'h022081B3, 7'h33, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 5'd0, 1'b1, 1'b0}); // mul x3,x1,x2
`endif

    // Reset held two cycles
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset in_ready",  32'(in_ready), 32'd1);
    chk("reset imm",       imm, 32'd0);
    chk("reset d_pc",      d_pc, 32'd0);
    chk("reset opcode",    32'(opcode), 32'd0);

    // Table: one instruction in flight, execute always ready
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      offer(32'h100 + 32'(i * 4), vecs[i].inst);
      tick();
      in_valid = 1'b0;
      chk_head($sformatf("vec%0d", i), vecs[i], 32'h100 + 32'(i * 4));
      tick();
      chk($sformatf("vec%0d drained", i), 32'(out_valid), 32'd0);
      chk($sformatf("vec%0d zero rd", i), 32'(rd), 32'd0);
    end

    // Backpressure: three back-to-back offers with execute stalled
    out_ready = 1'b0;
    offer(32'h200, 32'h00100093);
    tick();
    chk("bp in_ready after 1", 32'(in_ready), 32'd1);
    offer(32'h204, 32'h00100113);
    tick();
    chk("bp in_ready after 2", 32'(in_ready), 32'd0);
    offer(32'h208, 32'h00100193);
    tick();
    chk("bp in_ready held",    32'(in_ready), 32'd0);
    chk("bp head stable pc",   d_pc, 32'h200);
    chk("bp head stable rd",   32'(rd), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp 2nd valid", 32'(out_valid), 32'd1);
    chk("bp 2nd pc",    d_pc, 32'h204);
    chk("bp 2nd rd",    32'(rd), 32'd2);
    chk("bp reopen",    32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp 3rd pc",    d_pc, 32'h208);
    chk("bp 3rd rd",    32'(rd), 32'd3);
    tick();
    chk("bp empty",     32'(out_valid), 32'd0);

    // Flush with a full buffer and a concurrent offer
    out_ready = 1'b0;
    offer(32'h300, 32'h00100093);
    tick();
    offer(32'h304, 32'h00100113);
    tick();
    chk("fl1 full", 32'(in_ready), 32'd0);
    offer(32'h308, 32'h00100193);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl1 out_valid", 32'(out_valid), 32'd0);
    chk("fl1 in_ready",  32'(in_ready), 32'd1);
    chk("fl1 d_pc",      d_pc, 32'd0);
    tick();
    chk("fl1 no ghost",  32'(out_valid), 32'd0);

    // Flush with one entry while an acceptable offer is present
    offer(32'h400, 32'h00100093);
    tick();
    offer(32'h404, 32'h00100113);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl2 out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("fl2 drop push", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    offer(32'h408, 32'h00100193);
    tick();
    in_valid = 1'b0;
    chk("fl2 resume pc", d_pc, 32'h408);
    chk("fl2 resume rd", 32'(rd), 32'd3);
    tick();

    // Reset overrides a concurrent push and flush
    out_ready = 1'b0;
    offer(32'h500, 32'h00100093);
    tick();
    offer(32'h504, 32'h00100113);
    reset_n = 1'b0;
    flush = 1'b1;
    tick();
    reset_n = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("rst2 out_valid", 32'(out_valid), 32'd0);
    chk("rst2 in_ready",  32'(in_ready), 32'd1);
    tick();
    chk("rst2 no ghost",  32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
